operand_mux_stage: RTL
======================

Name: operand_mux_stage

Overview:
Parametrised, registered N-way operand selector for the 19-bit datapath. Picks one of NUM_IN IN_W-bit sources, zero- or sign-extends it to OUT_W bits, and presents it through a valid/ready interface. A 2-entry skid buffer decouples ALU-side stalls from the source side without creating a combinational ready path. Sits between the register-file/immediate sources and the ALU B operand.

Parameters:
NUM_IN, 4, number of source operands (2..8)
IN_W, 14, width of each source operand
OUT_W, 19, output width; must be >= IN_W
SEL_W, 2, select width; must be >= ceil(log2(NUM_IN))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_bus  in  NUM_IN*IN_W  packed sources; source k = in_bus[k*IN_W +: IN_W]
in_sel  in  SEL_W  source index
in_sext  in  1  1 = sign-extend, 0 = zero-extend
in_valid  in  1  source-side transaction valid
in_ready  out  1  stage can accept; registered
out_data  out  OUT_W  extended selected operand
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
sel_err  out  1  sticky out-of-range-select flag (OPMUX_SEL_CHECK_EN only; else tied 0)

Behaviour:
- Reset (async, while rst=1): state EMPTY, out_valid=0, out_data=0, in_ready=1, skid register=0, sel_err=0.
- Input transfer: in_valid & in_ready at a clk edge. Output transfer: out_valid & out_ready at a clk edge.
- Datapath per accepted beat: src = source[in_sel]; if in_sel >= NUM_IN, src = 0. ext = in_sext ? {(OUT_W-IN_W){src[IN_W-1]}, src} : {(OUT_W-IN_W){0}, src}. OUT_W == IN_W means no extension.
- Latency: an accepted beat appears on out_data/out_valid on the next edge when the stage is empty (1 cycle). Full throughput: 1 beat/cycle while out_ready=1.
- States: EMPTY (main empty), ONE (main full, skid empty), TWO (main and skid full).
  EMPTY: in xfer -> ONE, main<=ext.
  ONE: in xfer, no out xfer -> TWO, skid<=ext. Out xfer, no in xfer -> EMPTY. Both -> ONE, main<=ext. Neither -> hold.
  TWO: in_ready=0. Out xfer -> ONE, main<=skid. No out xfer -> hold.
- in_ready = (state != TWO), driven from the state register only; no combinational path from out_ready.
- out_valid = (state != EMPTY); out_data = main register; it is stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- in_sel and in_sext are sampled only on an input transfer; they are ignored otherwise.
- Reset mid-operation: all buffered beats are discarded and every output returns to its reset value immediately.
- in_valid=1 while in_ready=0: no transfer takes place; the source must hold its values.

Optional Feature:
OPMUX_SEL_CHECK_EN — defined: an input transfer with in_sel >= NUM_IN sets sel_err=1. sel_err stays set until rst, and the beat still passes through as zero. Undefined: sel_err is constant 0 and no checking logic is built. Out-of-range data is zero in both cases.

Test Plan:
- Reset: assert rst mid-stream with state TWO -> out_valid=0, out_data=0, in_ready=1 immediately; no stale beat after release.
- Extension: NUM_IN=4; source2=14'h2ABC, sel=2, sext=1, out_ready=1 -> next cycle out_data=19'h7EABC. Same with sext=0 -> 19'h02ABC.
- Backpressure: out_ready=0, feed beats A,B,C on consecutive cycles -> A and B accepted, in_ready=0 from the cycle after B, C held. Then out_ready=1 -> out_data sequence A,B,C with no loss.
- Throughput: in_valid=out_ready=1 for 16 cycles with incrementing sources -> 16 outputs in order at 1/cycle, first one 1 cycle after the first input.
- Out-of-range: NUM_IN=3, SEL_W=2, sel=3 -> out_data=0. With OPMUX_SEL_CHECK_EN, sel_err rises after that transfer and stays 1 until rst.
- Bubble: in_valid toggling 1,0,1 with out_ready=1 -> out_valid pattern 0,1,0,1 and the state returns to EMPTY between beats.

Source files
------------

// File: rtl/operand_mux_stage.sv
// Registered N-way operand selector with zero/sign extension and a 2-entry skid buffer.
// Optional select range checking is enabled by defining OPMUX_SEL_CHECK_EN.
module operand_mux_stage #(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned IN_W   = 14,
   parameter int unsigned OUT_W  = 19,
   parameter int unsigned SEL_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN*IN_W-1:0]   in_bus,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_sext,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sel_err
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [OUT_W-1:0] main_nxt;
   logic [OUT_W-1:0] skid_q;
   logic [OUT_W-1:0] skid_nxt;
   logic [IN_W-1:0]  src;
   logic [OUT_W-1:0] ext;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Source select; an index with no matching source yields zero.
   always_comb begin
      src = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            src = in_bus[k*IN_W +: IN_W];
         end
      end
   end

   if (OUT_W > IN_W) begin : g_ext
      assign ext = {{(OUT_W-IN_W){in_sext & src[IN_W-1]}}, src};
   end else begin : g_noext
      assign ext = src;
   end

   // State and data registers; handshake flags are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         out_data  <= '0;
         skid_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_data  <= main_nxt;
         skid_q    <= skid_nxt;
         in_ready  <= (state_nxt != TWO);
         out_valid <= (state_nxt != EMPTY);
      end
   end

   always_comb begin
      state_nxt = state;
      main_nxt  = out_data;
      skid_nxt  = skid_q;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               state_nxt = ONE;
               main_nxt  = ext;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_nxt = TWO;
               skid_nxt  = ext;
            end else if (!in_xfer && out_xfer) begin
               state_nxt = EMPTY;
            end else if (in_xfer && out_xfer) begin
               main_nxt  = ext;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_nxt = ONE;
               main_nxt  = skid_q;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

`ifdef OPMUX_SEL_CHECK_EN
   logic sel_oor;
   assign sel_oor = (32'(in_sel) >= NUM_IN);

   // Sticky flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err <= 1'b0;
      end else if (in_xfer && sel_oor) begin
         sel_err <= 1'b1;
      end
   end
`else
   assign sel_err = 1'b0;
`endif

endmodule
